// File: rtl/lda_pixel_writer.sv
// lda_pixel_writer: downstream stage of the LDA datapath.
// Clips each plotted pixel to the visible screen, converts it to a linear
// framebuffer address, queues it in a small FIFO and drains the queue into a
// registered valid/ready write port. Status flags report queue fill level and
// error conditions back to the LDA controller.
module lda_pixel_writer #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_PLOT,
  input  logic [8:0]        i_X,
  input  logic [8:0]        i_Y,
  input  logic [2:0]        i_COLOR,
  input  logic              i_CLEAR_ERR,
  output logic              o_FULL,
  output logic              o_ALMOST_FULL,
  output logic              o_IDLE,
  output logic              o_OVERFLOW,
  output logic [7:0]        o_DROP_CNT,
  output logic              o_WE,
  output logic [ADDR_W-1:0] o_ADDR,
  output logic [2:0]        o_WDATA,
  input  logic              i_READY
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 3;

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_C   = CNT_W'(DEPTH - 2);
  localparam logic [9:0]       SCREEN_W_C = 10'(SCREEN_W);
  localparam logic [9:0]       SCREEN_H_C = 10'(SCREEN_H);

  // Linear address Y*SCREEN_W + X; the default width is built from two shifts.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [8:0] x,
                                                   input logic [8:0] y);
    logic [ADDR_W-1:0] xe;
    logic [ADDR_W-1:0] ye;
    xe = ADDR_W'(x);
    ye = ADDR_W'(y);
    if (SCREEN_W == 320) begin
      calc_addr = (ye << 4'd8) + (ye << 4'd6) + xe;
    end else begin
      calc_addr = ye * ADDR_W'(SCREEN_W) + xe;
    end
  endfunction

  // Saturating increment for the clip counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  // Storage and registered state
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [2:0]         wdata_q, wdata_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  // Decoded events for this cycle
  logic               in_range_s;
  logic               pop_s;
  logic               push_s;
  logic               clip_evt_s;
  logic               ovf_evt_s;
  logic [ENTRY_W-1:0] head_s;

  // Event decode: clipping, pop/push qualification and overflow detection.
  always_comb begin
    in_range_s = ({1'b0, i_X} < SCREEN_W_C) && ({1'b0, i_Y} < SCREEN_H_C);
    head_s     = mem_q[rd_ptr_q];
    pop_s      = (count_q != {CNT_W{1'b0}}) && (!we_q || i_READY);
    // A full queue still accepts a pixel when the head leaves on the same edge.
    push_s     = i_PLOT && in_range_s && ((count_q < DEPTH_C) || pop_s);
    clip_evt_s = i_PLOT && !in_range_s;
    ovf_evt_s  = i_PLOT && in_range_s && !push_s;
  end

  // Next-state computation for pointers, fill count, output register and flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Output register loads a new head whenever the current write is done or absent.
    if (pop_s) begin
      we_d    = 1'b1;
      addr_d  = head_s[ENTRY_W-1:3];
      wdata_d = head_s[2:0];
    end else if (we_q && i_READY) begin
      we_d    = 1'b0;
    end else begin
      we_d    = we_q;
    end

    // Clear takes priority over an error event landing on the same edge.
    if (i_CLEAR_ERR) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      if (ovf_evt_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (clip_evt_s) begin
        drop_cnt_d = sat_inc8(drop_cnt_q);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      we_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= 3'd0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_q[wr_ptr_q] <= {calc_addr(i_X, i_Y), i_COLOR};
    end
  end

  // Status flags are decoded from registered state only.
  always_comb begin
    o_FULL        = (count_q == DEPTH_C);
    o_ALMOST_FULL = (count_q >= ALMOST_C);
    o_IDLE        = (count_q == {CNT_W{1'b0}}) && !we_q;
  end

  assign o_WE       = we_q;
  assign o_ADDR     = addr_q;
  assign o_WDATA    = wdata_q;
  assign o_OVERFLOW = overflow_q;
  assign o_DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_lda_pixel_writer.sv
// Self-checking bench for lda_pixel_writer: a vector table covers single
// pixel latency and streaming throughput; hand sequences cover backpressure,
// overflow, clipping saturation, boundary address and mid-drain reset.
module tb_lda_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_PLOT;
  logic [8:0]  i_X;
  logic [8:0]  i_Y;
  logic [2:0]  i_COLOR;
  logic        i_CLEAR_ERR;
  logic        i_READY;
  logic        o_FULL;
  logic        o_ALMOST_FULL;
  logic        o_IDLE;
  logic        o_OVERFLOW;
  logic [7:0]  o_DROP_CNT;
  logic        o_WE;
  logic [16:0] o_ADDR;
  logic [2:0]  o_WDATA;

  int checks = 0;
  int errors = 0;

  lda_pixel_writer dut (
    .clk(clk), .reset(reset), .i_PLOT(i_PLOT), .i_X(i_X), .i_Y(i_Y),
    .i_COLOR(i_COLOR), .i_CLEAR_ERR(i_CLEAR_ERR), .o_FULL(o_FULL),
    .o_ALMOST_FULL(o_ALMOST_FULL), .o_IDLE(o_IDLE), .o_OVERFLOW(o_OVERFLOW),
    .o_DROP_CNT(o_DROP_CNT), .o_WE(o_WE), .o_ADDR(o_ADDR), .o_WDATA(o_WDATA),
    .i_READY(i_READY)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic        plot;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [2:0]  c;
    logic        ready;
    logic        we;
    logic [16:0] addr;
    logic [2:0]  wdata;
    logic        idle;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One active edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic plot, input int x, input int y, input int c);
    i_PLOT  = plot;
    i_X     = 9'(x);
    i_Y     = 9'(y);
    i_COLOR = 3'(c);
  endtask

  initial begin
    int exp_cnt;
    logic we_seen;
    logic ovf_seen;

    // Table: single pixel (rows 0-2), then streaming row Y=239 (rows 3-14)
    tbl[0] = '{1'b1, 9'd5, 9'd2, 3'b101, 1'b1, 1'b0, 17'd0,   3'd0, 1'b0};
    tbl[1] = '{1'b0, 9'd0, 9'd0, 3'd0,   1'b1, 1'b1, 17'd645, 3'd5, 1'b0};
    tbl[2] = '{1'b0, 9'd0, 9'd0, 3'd0,   1'b1, 1'b0, 17'd0,   3'd0, 1'b1};
    for (int k = 0; k < 12; k++) begin
      tbl[3+k].plot  = (k < 10);
      tbl[3+k].x     = 9'(k);
      tbl[3+k].y     = 9'd239;
      tbl[3+k].c     = 3'(k);
      tbl[3+k].ready = 1'b1;
      tbl[3+k].we    = (k >= 1 && k <= 10);
      tbl[3+k].addr  = 17'(76480 + k - 1);
      tbl[3+k].wdata = 3'(k - 1);
      tbl[3+k].idle  = (k == 11);
    end

    // Reset
    reset = 1'b0; drive(1'b0, 0, 0, 0); i_CLEAR_ERR = 1'b0; i_READY = 1'b1;
    step(); step();
    check("rst_we", o_WE, 0);
    check("rst_addr", o_ADDR, 0);
    check("rst_wdata", o_WDATA, 0);
    check("rst_idle", o_IDLE, 1);
    check("rst_full", o_FULL, 0);
    check("rst_afull", o_ALMOST_FULL, 0);
    check("rst_ovf", o_OVERFLOW, 0);
    check("rst_drop", o_DROP_CNT, 0);
    reset = 1'b1;

    // Table-driven vectors
    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].plot, int'(tbl[r].x), int'(tbl[r].y), int'(tbl[r].c));
      i_READY = tbl[r].ready;
      step();
      check($sformatf("vec%0d_we", r), o_WE, tbl[r].we);
      check($sformatf("vec%0d_idle", r), o_IDLE, tbl[r].idle);
      if (tbl[r].we) begin
        check($sformatf("vec%0d_addr", r), o_ADDR, tbl[r].addr);
        check($sformatf("vec%0d_wdata", r), o_WDATA, tbl[r].wdata);
      end
    end
    drive(1'b0, 0, 0, 0);

    // Backpressure fill: p0 sits in the output register, FIFO holds 8 more
    i_READY = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      drive(1'b1, n + 9, 1, n);
      step();
      exp_cnt = (n == 1) ? 1 : ((n - 1 > 8) ? 8 : n - 1);
      check($sformatf("fill%0d_afull", n), o_ALMOST_FULL, exp_cnt >= 6);
      check($sformatf("fill%0d_full", n), o_FULL, exp_cnt == 8);
      check($sformatf("fill%0d_ovf", n), o_OVERFLOW, n >= 10);
      check($sformatf("fill%0d_we", n), o_WE, n >= 2);
      if (n >= 2) begin
        check($sformatf("fill%0d_hold_addr", n), o_ADDR, 330);
        check($sformatf("fill%0d_hold_wdata", n), o_WDATA, 1);
      end
    end
    // Clear alone, clear racing a new overflow, then overflow again
    drive(1'b0, 0, 0, 0); i_CLEAR_ERR = 1'b1;
    step();
    check("clr_ovf", o_OVERFLOW, 0);
    check("clr_full", o_FULL, 1);
    drive(1'b1, 50, 1, 0);
    step();
    check("clr_wins_ovf", o_OVERFLOW, 0);
    i_CLEAR_ERR = 1'b0; drive(1'b1, 51, 1, 0);
    step();
    check("reovf", o_OVERFLOW, 1);
    // Push into a full FIFO on the same edge as a pop: accepted
    i_READY = 1'b1; drive(1'b1, 100, 1, 7);
    step();
    check("fullpush_we", o_WE, 1);
    check("fullpush_addr", o_ADDR, 331);
    check("fullpush_wdata", o_WDATA, 2);
    check("fullpush_full", o_FULL, 1);
    drive(1'b0, 0, 0, 0);
    for (int j = 2; j <= 8; j++) begin
      step();
      check($sformatf("drain%0d_we", j), o_WE, 1);
      check($sformatf("drain%0d_addr", j), o_ADDR, 330 + j);
      check($sformatf("drain%0d_wdata", j), o_WDATA, (j + 1) % 8);
    end
    step();
    check("drain_q_addr", o_ADDR, 420);
    check("drain_q_wdata", o_WDATA, 7);
    step();
    check("drain_end_we", o_WE, 0);
    check("drain_end_idle", o_IDLE, 1);
    i_CLEAR_ERR = 1'b1;
    step();
    i_CLEAR_ERR = 1'b0;
    check("drain_clr_ovf", o_OVERFLOW, 0);

    // Clipping
    drive(1'b1, 320, 0, 1);
    step();
    check("clipx_drop", o_DROP_CNT, 1);
    drive(1'b1, 0, 240, 1);
    step();
    check("clipy_drop", o_DROP_CNT, 2);
    we_seen = 1'b0; ovf_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) drive(1'b1, 320 + (i % 150), 0, i);
      else            drive(1'b1, 0, 240 + (i % 200), i);
      step();
      we_seen  = we_seen | o_WE;
      ovf_seen = ovf_seen | o_OVERFLOW;
    end
    check("clip_sat_drop", o_DROP_CNT, 255);
    check("clip_no_we", we_seen, 0);
    check("clip_no_ovf", ovf_seen, 0);
    check("clip_idle", o_IDLE, 1);
    i_CLEAR_ERR = 1'b1; drive(1'b1, 400, 0, 0);
    step();
    check("clip_clr_wins", o_DROP_CNT, 0);
    i_CLEAR_ERR = 1'b0;

    // Last visible pixel
    drive(1'b1, 319, 239, 6);
    step();
    check("corner_drop", o_DROP_CNT, 0);
    drive(1'b0, 0, 0, 0);
    step();
    check("corner_we", o_WE, 1);
    check("corner_addr", o_ADDR, 76799);
    check("corner_wdata", o_WDATA, 6);
    step();
    check("corner_idle", o_IDLE, 1);

    // Stall stability, then reset mid-drain with 4 queued
    i_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k, 3, k + 1);
      step();
    end
    drive(1'b0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("stall%0d_we", s), o_WE, 1);
      check($sformatf("stall%0d_addr", s), o_ADDR, 960);
      check($sformatf("stall%0d_wdata", s), o_WDATA, 1);
    end
    i_READY = 1'b1; reset = 1'b0;
    step();
    check("midrst_we", o_WE, 0);
    check("midrst_idle", o_IDLE, 1);
    check("midrst_full", o_FULL, 0);
    reset = 1'b1;
    we_seen = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      we_seen = we_seen | o_WE;
    end
    check("postrst_no_we", we_seen, 0);
    check("postrst_idle", o_IDLE, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
